pwm_peripheral: RTL

PWM output stage directly downstream of the SPI register file. It consumes the five configuration registers: output enables, PWM-mode enables and the shared duty cycle. It drives 16 registered output pins, each either forced low, held static high, or driven by one shared 8-bit PWM waveform. Duty-cycle changes are double-buffered and take effect only at a period boundary, so no PWM period is ever truncated or glitched.

---
 rtl/pwm_peripheral.sv | 70 +++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage fed by the SPI register file: each pin is forced
// low, held static high, or follows one shared 8-bit PWM waveform.
module pwm_peripheral #(
  parameter int PRESCALE = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;
  logic [7:0]       cnt;
  logic [7:0]       duty_sh;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      pwm_mask;
  logic             active;
  logic             tick;
  logic             level;

  // Full-scale duty saturates to a constant high instead of 255/256.
  function automatic logic pwm_level(input logic [7:0] c, input logic [7:0] d);
    return (d == 8'hFF) || (c < d);
  endfunction

  always_comb begin
    en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    pwm_mask = en_out & en_pwm;
    active   = |pwm_mask;
    tick     = (pre == PRE_MAX);
    level    = pwm_level(cnt, duty_sh);
  end

  // Output register stage: pins and period marker from this cycle's counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
      pre          <= '0;
      cnt          <= 8'h00;
      duty_sh      <= 8'h00;
    end else begin
      out          <= (en_out & ~en_pwm) | (pwm_mask & {16{level}});
      period_start <= active && (cnt == 8'h00) && (pre == '0);
      if (!active) begin
        pre     <= '0;
        cnt     <= 8'h00;
        duty_sh <= pwm_duty_cycle;
      end else if (tick) begin
        pre <= '0;
        cnt <= cnt + 8'd1;
        // Shadow only reloads at the wrap so a running period is never cut short.
        if (cnt == 8'hFF) duty_sh <= pwm_duty_cycle;
      end else begin
        pre <= pre + PRE_W'(1);
      end
    end
  end

endmodule
